// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter: round-robin sequencer sharing a 2-read/1-write register memory among N requesters
module reg_port_arbiter #(
  parameter int N     = 2,
  parameter int DEPTH = 5,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_we,
  input  logic [N*AW-1:0] req_a1,
  input  logic [N*AW-1:0] req_a2,
  input  logic [N*AW-1:0] req_a3,
  input  logic [N*DW-1:0] req_wd,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    rsp_vld,
  output logic            rsp_err,
  output logic [DW-1:0]   rsp_rd1,
  output logic [DW-1:0]   rsp_rd2,
  output logic            busy,
  output logic [AW-1:0]   rf_a1,
  output logic [AW-1:0]   rf_a2,
  output logic [AW-1:0]   rf_a3,
  output logic [47:0]     rf_wd3,
  output logic            rf_rw,
  input  logic [DW-1:0]   rf_rd1,
  input  logic [DW-1:0]   rf_rd2
);
  localparam int IW = $clog2(N);
  localparam logic [N-1:0] one = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, own, win, idx;
  logic found, we, ok1, ok2, ok3, legal, issue, resp;
  logic [AW-1:0] a1, a2, a3;
  logic [DW-1:0] wd;
  // descending scan so the candidate closest to ptr is the one left standing
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (found ? ISSUE : IDLE) : state == ISSUE ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
      we    <= 1'b0;
      a1    <= '0;
      a2    <= '0;
      a3    <= '0;
      wd    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        ptr <= int'(win) == N - 1 ? '0 : win + 1'b1;
        own <= win;
        we  <= req_we[win];
        a1  <= req_a1[int'(win)*AW +: AW];
        a2  <= req_a2[int'(win)*AW +: AW];
        a3  <= req_a3[int'(win)*AW +: AW];
        wd  <= req_wd[int'(win)*DW +: DW];
      end
    end
  end
  assign ok1   = 32'(a1) < DEPTH;
  assign ok2   = 32'(a2) < DEPTH;
  assign ok3   = 32'(a3) < DEPTH;
  assign legal = ok1 && ok2 && (!we || ok3);
  assign issue = state == ISSUE;
  assign resp  = state == RESP;
  assign busy  = state != IDLE;
  // gnt is combinational from req, so it is also held off while reset is asserted
  assign gnt     = (rst && state == IDLE && found) ? one << win : '0;
  assign rf_a1   = issue && ok1 ? a1 : '0;
  assign rf_a2   = issue && ok2 ? a2 : '0;
  assign rf_a3   = issue && ok3 ? a3 : '0;
  assign rf_wd3  = issue ? 48'(wd) : '0;
  assign rf_rw   = issue && we && legal;
  assign rsp_vld = resp ? one << own : '0;
  assign rsp_err = resp && !legal;
  assign rsp_rd1 = resp && legal ? rf_rd1 : '0;
  assign rsp_rd2 = resp && legal ? rf_rd2 : '0;
endmodule

// File: tb/tb_reg_port_arbiter.sv
// tb_reg_port_arbiter: randomized round-robin arbitration against a register-memory reference model
module tb_reg_port_arbiter;
  localparam int N = 2, DEPTH = 5, AW = 5, DW = 32;
  logic clk = 0, rst = 0;
  logic [N-1:0] req = '0, req_we = '0;
  logic [N*AW-1:0] req_a1 = '0, req_a2 = '0, req_a3 = '0;
  logic [N*DW-1:0] req_wd = '0;
  logic [N-1:0] gnt, rsp_vld;
  logic rsp_err, busy, rf_rw;
  logic [DW-1:0] rsp_rd1, rsp_rd2, rf_rd1 = '0, rf_rd2 = '0;
  logic [AW-1:0] rf_a1, rf_a2, rf_a3;
  logic [47:0] rf_wd3;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] saved [DEPTH];
  typedef struct { int owner; bit err; logic [DW-1:0] rd1, rd2; int at; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, ptr_m = 0, cool = 0;
  bit i_rw;
  logic [AW-1:0] i_a1, i_a2, i_a3;
  logic [DW-1:0] i_wd;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  reg_port_arbiter #(.N(N), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_a1(req_a1), .req_a2(req_a2),
    .req_a3(req_a3), .req_wd(req_wd), .gnt(gnt), .rsp_vld(rsp_vld), .rsp_err(rsp_err),
    .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2), .busy(busy), .rf_a1(rf_a1), .rf_a2(rf_a2),
    .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_rw(rf_rw), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );
  // registered-read memory, write before read
  always @(posedge clk) begin
    if (rf_rw && int'(rf_a3) < DEPTH) mem[rf_a3] = rf_wd3[DW-1:0];
    rf_rd1 <= int'(rf_a1) < DEPTH ? mem[rf_a1] : '0;
    rf_rd2 <= int'(rf_a2) < DEPTH ? mem[rf_a2] : '0;
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // one clock: predict the grant from the round-robin rules, queue the expected response
  task automatic step();
    int w;
    logic [N-1:0] eg;
    logic [AW-1:0] a1, a2, a3;
    logic [DW-1:0] wd;
    bit we, err;
    exp_t e;
    @(negedge clk);
    chk("busy", busy, cool != 0);
    chk("rf_rw", rf_rw, cool == 2 && i_rw);
    if (cool == 2) begin
      chk("rf_a1", rf_a1, i_a1);
      chk("rf_a2", rf_a2, i_a2);
      if (i_rw) begin
        chk("rf_a3", rf_a3, i_a3);
        chk("rf_wd3", rf_wd3, 48'(i_wd));
      end
    end
    w = -1;
    if (cool == 0)
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", gnt, eg);
    if (cool > 0) cool--;
    if (w >= 0) begin
      we = req_we[w];
      a1 = req_a1[w*AW +: AW];
      a2 = req_a2[w*AW +: AW];
      a3 = req_a3[w*AW +: AW];
      wd = req_wd[w*DW +: DW];
      err = int'(a1) >= DEPTH || int'(a2) >= DEPTH || (we && int'(a3) >= DEPTH);
      i_rw = we && !err;
      i_a1 = int'(a1) < DEPTH ? a1 : '0;
      i_a2 = int'(a2) < DEPTH ? a2 : '0;
      i_a3 = a3;
      i_wd = wd;
      if (i_rw) ref_mem[a3] = wd;
      e.owner = w;
      e.err = err;
      e.rd1 = err ? '0 : ref_mem[a1];
      e.rd2 = err ? '0 : ref_mem[a2];
      e.at = cyc + 2;
      q.push_back(e);
      ptr_m = (w + 1) % N;
      cool = 2;
    end
    @(posedge clk);
    #1;
    if (w >= 0) req[w] = 1'b0;
  endtask
  task automatic set_req(int i, bit we, int a1, int a2, int a3, logic [DW-1:0] wd);
    req_we[i] = we;
    req_a1[i*AW +: AW] = AW'(a1);
    req_a2[i*AW +: AW] = AW'(a2);
    req_a3[i*AW +: AW] = AW'(a3);
    req_wd[i*DW +: DW] = wd;
  endtask
  always @(negedge clk) begin
    if (rsp_vld != '0) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got rsp_vld=%b expected none", rsp_vld);
      end else begin
        automatic exp_t e = q.pop_front();
        automatic logic [N-1:0] ev = '0;
        ev[e.owner] = 1'b1;
        chk("rsp_vld", rsp_vld, ev);
        chk("rsp_time", cyc, e.at);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_rd1", rsp_rd1, e.rd1);
        chk("rsp_rd2", rsp_rd2, e.rd2);
      end
    end
  end
  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      mem[k] = '0;
      ref_mem[k] = '0;
    end
    req = 2'b11;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_rw", rf_rw, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1;
    repeat (6) step();
    set_req(0, 1, 2, 0, 2, 32'hDEADBEEF);
    req = 2'b01;
    repeat (2) step();
    chk("t2_vld", rsp_vld, 2'b01);
    chk("t2_rd1", rsp_rd1, 32'hDEADBEEF);
    step();
    set_req(0, 0, 2, 1, 0, '0);
    set_req(1, 0, 0, 2, 0, '0);
    for (int t = 0; t < 12; t++) begin
      req = 2'b11;
      step();
    end
    req = '0;
    repeat (3) step();
    set_req(1, 1, 1, 3, 7, $urandom);
    req = 2'b10;
    repeat (3) step();
    for (int k = 0; k < DEPTH; k++) begin
      set_req(0, 0, k, DEPTH - 1 - k, 0, '0);
      req = 2'b01;
      repeat (3) step();
    end
    saved = ref_mem;
    set_req(0, 1, 1, 1, 1, 32'h12345678);
    req = 2'b01;
    step();
    #2 rst = 0;
    #1;
    chk("t5_rw", rf_rw, 0);
    chk("t5_busy", busy, 0);
    q.delete();
    ref_mem = saved;
    cool = 0;
    ptr_m = 0;
    i_rw = 0;
    req = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1;
    set_req(0, 0, 1, 1, 0, '0);
    set_req(1, 0, 1, 0, 0, '0);
    req = 2'b11;
    repeat (6) step();
    for (int t = 0; t < 400; t++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_req(i, 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, 5), $urandom);
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
    end
    req = '0;
    repeat (4) step();
    chk("drain", q.size(), 0);
    for (int k = 0; k < DEPTH; k++) chk("mem", mem[k], ref_mem[k]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
